// File: rtl/mem_arb2.sv
// Two-requester arbiter in front of a single-port RAM with a registered read port.
// One access per cycle, round-robin on conflict, optional ownership locking,
// and a one-cycle tagged return path that routes mem_dout to the issuing requester.
module mem_arb2 #(
  parameter int ADD_WIDTH = 10,
  parameter int DAT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // requester 0
  input  logic                 req0,
  input  logic                 lock0,
  input  logic                 we0,
  input  logic [ADD_WIDTH-1:0] add0,
  input  logic [DAT_WIDTH-1:0] din0,
  output logic                 ack0,
  output logic [DAT_WIDTH-1:0] rdata0,
  output logic                 rvalid0,
  // requester 1
  input  logic                 req1,
  input  logic                 lock1,
  input  logic                 we1,
  input  logic [ADD_WIDTH-1:0] add1,
  input  logic [DAT_WIDTH-1:0] din1,
  output logic                 ack1,
  output logic [DAT_WIDTH-1:0] rdata1,
  output logic                 rvalid1,
  // single-port RAM
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADD_WIDTH-1:0] mem_add,
  output logic [DAT_WIDTH-1:0] mem_din,
  input  logic [DAT_WIDTH-1:0] mem_dout,
  // arbiter state for observation
  output logic [1:0]           dbg_state
);

  // Handshake: a requester raises reqN with we/add/din and holds them stable
  // until the cycle ackN=1; that cycle is exactly one RAM access. One cycle
  // later rvalidN=1 for one cycle with rdataN (read data or written data).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   gnt0;
  logic   gnt1;
  logic   ret_valid;
  logic   ret_owner;
  logic [DAT_WIDTH-1:0] hold0;
  logic [DAT_WIDTH-1:0] hold1;

  // State register plus the round-robin pointer (last requester granted).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (ack0)      last <= 1'b0;
      else if (ack1) last <= 1'b1;
    end
  end

  // Grant decision and next state; an owner keeps priority while it requests.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        // on conflict the requester not granted last wins
        if (req0 && (!req1 || last)) gnt0 = 1'b1;
        else if (req1)               gnt1 = 1'b1;
        if (gnt0 && lock0)      state_nxt = OWN0;
        else if (gnt1 && lock1) state_nxt = OWN1;
      end
      OWN0: begin
        // owner dropping its request costs one idle cycle before re-arbitration
        if (req0) begin
          gnt0 = 1'b1;
          if (lock0) state_nxt = OWN0;
        end
      end
      OWN1: begin
        if (req1) begin
          gnt1 = 1'b1;
          if (lock1) state_nxt = OWN1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Acks and the RAM command mux; nothing is issued while reset is held.
  always_comb begin
    ack0    = gnt0 & reset_n;
    ack1    = gnt1 & reset_n;
    mem_en  = ack0 | ack1;
    mem_we  = 1'b0;
    mem_add = '0;
    mem_din = '0;
    if (ack0) begin
      mem_we  = we0;
      mem_add = add0;
      mem_din = din0;
    end else if (ack1) begin
      mem_we  = we1;
      mem_add = add1;
      mem_din = din1;
    end
  end

  // Return tag: which requester owns the data appearing on mem_dout next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ret_valid <= 1'b0;
      ret_owner <= 1'b0;
    end else begin
      ret_valid <= mem_en;
      ret_owner <= ack1;
    end
  end

  // Per-requester copy of the last returned data, shown while rvalid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rvalid0) hold0 <= mem_dout;
      if (rvalid1) hold1 <= mem_dout;
    end
  end

  // Return steering: the RAM output passes straight through in the return cycle.
  always_comb begin
    rvalid0   = ret_valid & ~ret_owner;
    rvalid1   = ret_valid & ret_owner;
    rdata0    = rvalid0 ? mem_dout : hold0;
    rdata1    = rvalid1 ? mem_dout : hold1;
    dbg_state = state;
  end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: behavioural RAM, a rule-level reference model checked
// every cycle on the falling edge, and directed scenarios with literal checks.
module tb_mem_arb2;

  localparam int AW = 10;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          req0, lock0, we0, req1, lock1, we1;
  logic [AW-1:0] add0, add1;
  logic [DW-1:0] din0, din1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_add;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [1:0]    dbg_state;

  mem_arb2 #(.ADD_WIDTH(AW), .DAT_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .lock0(lock0), .we0(we0), .add0(add0), .din0(din0),
    .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .lock1(lock1), .we1(we1), .add1(add1), .din1(din1),
    .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_add(mem_add), .mem_din(mem_din),
    .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // Single-port RAM, registered output, write-through on writes.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_add] <= mem_din;
        mem_dout     <= mem_din;
      end else begin
        mem_dout <= ram[mem_add];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 = nobody), last grant, memory image, return queue.
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  int            own_q[$];
  int            m_own;
  int            m_last;
  logic [DW-1:0] m_rd [2];
  int            g, o;
  logic          rq [2];
  logic          lk [2];
  logic          wv [2];
  logic [AW-1:0] av [2];
  logic [DW-1:0] dv [2];
  logic [DW-1:0] d;
  logic          e_ack0, e_ack1, e_we, e_rv0, e_rv1;
  logic [AW-1:0] e_add;
  logic [DW-1:0] e_din;

  always @(negedge clk) begin
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_we = 1'b0; e_add = '0; e_din = '0;
    e_rv0 = 1'b0; e_rv1 = 1'b0;
    if (!reset_n) begin
      m_own = -1;
      m_last = 1;
      exp_q.delete();
      own_q.delete();
      m_rd[0] = '0;
      m_rd[1] = '0;
    end else begin
      // data for last cycle's grant comes back now
      if (own_q.size() > 0) begin
        o = own_q.pop_front();
        d = exp_q.pop_front();
        m_rd[o] = d;
        if (o == 0) e_rv0 = 1'b1;
        else        e_rv1 = 1'b1;
      end
      rq[0] = req0;  rq[1] = req1;
      lk[0] = lock0; lk[1] = lock1;
      wv[0] = we0;   wv[1] = we1;
      av[0] = add0;  av[1] = add1;
      dv[0] = din0;  dv[1] = din1;
      g = -1;
      if (m_own >= 0) begin
        if (rq[m_own]) g = m_own;
      end else if (rq[0] && rq[1]) g = 1 - m_last;
      else if (rq[0]) g = 0;
      else if (rq[1]) g = 1;
      if (g >= 0) begin
        e_ack0 = (g == 0);
        e_ack1 = (g == 1);
        e_we  = wv[g];
        e_add = av[g];
        e_din = dv[g];
        if (wv[g]) begin
          m_mem[av[g]] = dv[g];
          d = dv[g];
        end else begin
          d = m_mem[av[g]];
        end
        exp_q.push_back(d);
        own_q.push_back(g);
        m_last = g;
        m_own = lk[g] ? g : -1;
      end else begin
        m_own = -1;
      end
    end
    check("m_ack0", ack0, e_ack0);
    check("m_ack1", ack1, e_ack1);
    check("m_mem_en", mem_en, e_ack0 | e_ack1);
    check("m_mem_we", mem_we, e_we);
    check("m_mem_add", mem_add, e_add);
    check("m_mem_din", mem_din, e_din);
    check("m_rvalid0", rvalid0, e_rv0);
    check("m_rvalid1", rvalid1, e_rv1);
    check("m_rdata0", rdata0, m_rd[0]);
    check("m_rdata1", rdata1, m_rd[1]);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic l, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] dd);
    req0 = r; lock0 = l; we0 = w; add0 = a; din0 = dd;
  endtask

  task automatic set1(input logic r, input logic l, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] dd);
    req1 = r; lock1 = l; we1 = w; add1 = a; din1 = dd;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      m_mem[i] = '0;
    end
    reset_n = 1'b0;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);

    // write 0xA5 to 0x010 via req0, read it back via req1
    tick();
    reset_n = 1'b1;
    set0(1, 0, 1, 10'h010, 8'hA5);
    @(negedge clk);
    check("wr_ack0", ack0, 1);
    check("wr_mem_we", mem_we, 1);
    tick();
    set0(0, 0, 0, '0, '0);
    set1(1, 0, 0, 10'h010, '0);
    @(negedge clk);
    check("rd_ack1", ack1, 1);
    check("wr_ret_rvalid0", rvalid0, 1);
    check("wr_ret_rdata0", rdata0, 8'hA5);
    tick();
    set1(0, 0, 0, '0, '0);
    @(negedge clk);
    check("rd_rvalid1", rvalid1, 1);
    check("rd_rdata1", rdata1, 8'hA5);
    check("rd_rvalid0", rvalid0, 0);

    // leave last=0 with a return pending, then reset into a permanent conflict
    tick();
    set0(1, 0, 0, 10'h010, '0);
    @(negedge clk);
    check("pre_rst_ack0", ack0, 1);
    tick();
    reset_n = 1'b0;
    set0(1, 0, 0, 10'h000, '0);
    set1(1, 0, 0, 10'h001, '0);
    @(negedge clk);
    check("rst_drop_rvalid0", rvalid0, 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("conf_ack0", ack0, (k % 2) == 0);
      check("conf_ack1", ack1, (k % 2) == 1);
      check("conf_mem_en", mem_en, 1);
      tick();
    end
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);

    // lock: requester 0 holds ownership four cycles against requester 1
    tick();
    set0(1, 1, 0, 10'h010, '0);
    set1(1, 0, 0, 10'h011, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lock_ack0", ack0, 1);
      check("lock_ack1", ack1, 0);
      tick();
    end
    set0(0, 0, 0, '0, '0);
    @(negedge clk);
    check("lock_gap_en", mem_en, 0);
    tick();
    @(negedge clk);
    check("lock_then_ack1", ack1, 1);
    tick();
    set1(0, 0, 0, '0, '0);

    // preload 0..7 with 0x30+i, then read them back-to-back
    for (int i = 0; i < 8; i++) begin
      set0(1, 0, 1, AW'(i), DW'(8'h30 + i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      set0(1, 0, 0, AW'(i), '0);
      @(negedge clk);
      check("pipe_ack0", ack0, 1);
      if (i > 0) begin
        check("pipe_rvalid0", rvalid0, 1);
        check("pipe_rdata0", rdata0, 8'h30 + i - 1);
      end
      tick();
    end
    set0(0, 0, 0, '0, '0);
    @(negedge clk);
    check("pipe_last_rvalid0", rvalid0, 1);
    check("pipe_last_rdata0", rdata0, 8'h37);
    tick();
    @(negedge clk);
    check("pipe_hold_rdata0", rdata0, 8'h37);

    // write 0x5C to 0x3FF via req1, then read it back
    tick();
    set1(1, 0, 1, 10'h3FF, 8'h5C);
    @(negedge clk);
    check("wr3ff_ack1", ack1, 1);
    check("wr3ff_add", mem_add, 10'h3FF);
    tick();
    set1(1, 0, 0, 10'h3FF, '0);
    @(negedge clk);
    check("wr3ff_rvalid1", rvalid1, 1);
    check("wr3ff_rdata1", rdata1, 8'h5C);
    tick();
    set1(0, 0, 0, '0, '0);
    @(negedge clk);
    check("rd3ff_rvalid1", rvalid1, 1);
    check("rd3ff_rdata1", rdata1, 8'h5C);

    // reset lands between a read grant and its return
    tick();
    set1(1, 0, 0, 10'h010, '0);
    @(negedge clk);
    check("mid_ack1", ack1, 1);
    #1;
    reset_n = 1'b0;
    set1(0, 0, 0, '0, '0);
    @(negedge clk);
    check("mid_rvalid1", rvalid1, 0);
    check("mid_rdata1", rdata1, 0);
    tick();
    tick();
    reset_n = 1'b1;
    set0(1, 0, 0, 10'h000, '0);
    set1(1, 0, 0, 10'h001, '0);
    @(negedge clk);
    check("post_rst_ack0", ack0, 1);
    check("post_rst_rvalid1", rvalid1, 0);
    tick();
    set0(0, 0, 0, '0, '0);
    set1(0, 0, 0, '0, '0);
    @(negedge clk);
    check("post_rst_rvalid0", rvalid0, 1);
    tick();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
